bus_master: RTL

// - Initiator end of the 4-bit multiplexed instruction/IO bus. Runs the
//   8-subcycle bus frame, drives the 12-bit fetch address as three nibbles,

---
 rtl/bus_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bus_master.sv
// bus_master: initiator of the 4-bit multiplexed instruction/IO bus.
// Runs the 8-subcycle frame and sends the 12-bit fetch address as three nibbles.
// It captures the returned opcode and runs the bus side of SRC, WRR and RDR.
module bus_master #(
  parameter logic [3:0] IO_GROUP = 4'hE,
  parameter logic [3:0] OP_WRR   = 4'h2,
  parameter logic [3:0] OP_RDR   = 4'hA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic [11:0] pc_i,
  input  logic        src_req_i,
  input  logic [3:0]  src_id_i,
  input  logic [3:0]  wr_data_i,
  output logic [7:0]  opcode_o,
  output logic        opcode_vld_o,
  output logic [3:0]  rd_data_o,
  output logic        rd_vld_o,
  output logic [2:0]  cycle_o,
  output logic        sync_o,
  output logic        cmd_o,
  input  logic [3:0]  data_i,
  output logic [3:0]  data_o,
  output logic        data_en
);

  typedef enum logic [2:0] {
    C0 = 3'd0, C1 = 3'd1, C2 = 3'd2, C3 = 3'd3,
    C4 = 3'd4, C5 = 3'd5, C6 = 3'd6, C7 = 3'd7
  } cyc_t;

  // Values latched at the end of subcycle 5 and used in subcycle 6.
  typedef struct packed {
    logic       src;
    logic [3:0] src_id;
    logic [3:0] wr_data;
  } frame_req_t;

  cyc_t       state, state_nx;
  logic [11:0] fetch_addr;
  frame_req_t req;

  logic io_frame, is_wrr, is_rdr;

  // The high opcode nibble is valid from subcycle 4 onward. Before that it
  // belongs to the previous frame, so only later subcycles look at io_frame.
  assign io_frame = (opcode_o[7:4] == IO_GROUP);
  assign is_wrr   = io_frame && (opcode_o[3:0] == OP_WRR);
  assign is_rdr   = io_frame && (opcode_o[3:0] == OP_RDR);

  assign cycle_o      = state;
  assign sync_o       = (state == C7);
  assign opcode_vld_o = (state == C5);

  // Subcycle register. Halt freezes it in place, and reset restarts the frame.
  always_ff @(posedge clock) begin
    if (reset) state <= C0;
    else       state <= state_nx;
  end

  // Next subcycle plus the bus drive schedule decoded from the registers.
  always_comb begin
    state_nx = state;
    data_o   = 4'h0;
    data_en  = 1'b0;
    cmd_o    = 1'b1;
    case (state)
      C0: begin
        state_nx = C1;
        data_o   = fetch_addr[3:0];
        data_en  = 1'b1;
      end
      C1: begin
        state_nx = C2;
        data_o   = fetch_addr[7:4];
        data_en  = 1'b1;
      end
      C2: begin
        state_nx = C3;
        data_o   = fetch_addr[11:8];
        data_en  = 1'b1;
      end
      C3: state_nx = C4;
      C4: begin
        state_nx = C5;
        cmd_o    = !io_frame;
      end
      C5: state_nx = C6;
      C6: begin
        state_nx = C7;
        // SRC can only be pending outside an I/O frame, so the two never overlap.
        if (req.src) begin
          data_o  = req.src_id;
          data_en = 1'b1;
          cmd_o   = 1'b0;
        end else if (is_wrr) begin
          data_o  = req.wr_data;
          data_en = 1'b1;
        end
      end
      C7: state_nx = C0;
      default: state_nx = C0;
    endcase
    if (halt) state_nx = state;
  end

  // Frame data registers: opcode capture, SRC/WRR latch, RDR result, next address.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr <= 12'h000;
      opcode_o   <= 8'h00;
      rd_data_o  <= 4'h0;
      rd_vld_o   <= 1'b0;
      req        <= '0;
    end else if (!halt) begin
      case (state)
        C3: opcode_o[7:4] <= data_i;
        C4: opcode_o[3:0] <= data_i;
        C5: begin
          req.src     <= src_req_i && !io_frame;
          req.src_id  <= src_id_i;
          req.wr_data <= wr_data_i;
        end
        C6: begin
          if (is_rdr) begin
            rd_data_o <= data_i;
            rd_vld_o  <= 1'b1;
          end
        end
        C7: begin
          fetch_addr <= pc_i;
          rd_vld_o   <= 1'b0;
          req.src    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
